// File: rtl/secuenciador_programa_if.sv
// Bus between the MicroUAZ decoder/datapath and the program sequencer.
// The slave modport is the sequencer's view; the master modport is its environment.
interface secuenciador_programa_if #(
  parameter int AW    = 9,
  parameter int DEPTH = 4
);
  localparam int SPW = $clog2(DEPTH + 1);

  logic [AW-1:0]  i_Target;
  logic [2:0]     i_Cond;
  logic           i_Is_Jump;
  logic           i_Is_Call;
  logic           i_Is_Ret;
  logic           i_Is_Halt;
  logic           i_Mem_Req;
  logic           i_Mem_Ready;
  logic [2:0]     i_Flags;

  logic [AW-1:0]  o_Pc;
  logic           o_Rom_En;
  logic           o_Ir_Load;
  logic           o_Exec_En;
  logic           o_Halted;
  logic           o_Stack_Err;
  logic [SPW-1:0] o_Sp;

  modport slave (
    input  i_Target, i_Cond, i_Is_Jump, i_Is_Call, i_Is_Ret, i_Is_Halt,
           i_Mem_Req, i_Mem_Ready, i_Flags,
    output o_Pc, o_Rom_En, o_Ir_Load, o_Exec_En, o_Halted, o_Stack_Err, o_Sp
  );

  modport master (
    output i_Target, i_Cond, i_Is_Jump, i_Is_Call, i_Is_Ret, i_Is_Halt,
           i_Mem_Req, i_Mem_Ready, i_Flags,
    input  o_Pc, o_Rom_En, o_Ir_Load, o_Exec_En, o_Halted, o_Stack_Err, o_Sp
  );
endinterface

// File: rtl/secuenciador_programa.sv
// MicroUAZ program sequencer: Moore FSM stepping fetch/decode/exec/wait,
// owning the PC, conditional jumps and a hardware call/return stack.
module secuenciador_programa #(
  parameter int DEPTH = 4,
  parameter int AW    = 9
) (
  input  logic                   i_Clk,
  input  logic                   i_Reset,
  secuenciador_programa_if.slave bus
);
  localparam int SPW = $clog2(DEPTH + 1);
  localparam int IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_WAIT,
    S_HALT
  } state_t;

  state_t         state_q, state_d;
  logic [AW-1:0]  pc_q, pc_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           err_q, err_d;
  logic [AW-1:0]  stack_q [DEPTH];
  logic           push;
  logic [AW-1:0]  pcInc;
  logic [SPW-1:0] spInc, spDec;
  logic [IW-1:0]  pushIdx, popIdx;
  logic           condOk;

  assign pcInc   = pc_q + 1'b1;
  assign spInc   = sp_q + 1'b1;
  assign spDec   = sp_q - 1'b1;
  assign pushIdx = sp_q[IW-1:0];
  assign popIdx  = spDec[IW-1:0];

  always_comb begin
    condOk = 1'b0;
    case (bus.i_Cond)
      3'b000:  condOk = 1'b0;
      3'b001:  condOk = 1'b1;
      3'b010:  condOk = bus.i_Flags[0];
      3'b011:  condOk = ~bus.i_Flags[0];
      3'b100:  condOk = bus.i_Flags[1];
      3'b101:  condOk = ~bus.i_Flags[1];
      3'b110:  condOk = bus.i_Flags[2];
      default: condOk = ~bus.i_Flags[2];
    endcase
  end

  // Commit happens only when leaving EXEC for FETCH/HALT or leaving WAIT.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    sp_d    = sp_q;
    err_d   = err_q;
    push    = 1'b0;
    unique case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (bus.i_Is_Halt) begin
          state_d = S_HALT;
        end else if (bus.i_Is_Ret) begin
          if (sp_q == '0) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            pc_d    = stack_q[popIdx];
            sp_d    = spDec;
            state_d = S_FETCH;
          end
        end else if (bus.i_Is_Call) begin
          if (sp_q == SP_FULL) begin
            err_d   = 1'b1;
            state_d = S_HALT;
          end else begin
            push    = 1'b1;
            sp_d    = spInc;
            pc_d    = bus.i_Target;
            state_d = S_FETCH;
          end
        end else if (bus.i_Is_Jump) begin
          pc_d    = condOk ? bus.i_Target : pcInc;
          state_d = S_FETCH;
        end else if (bus.i_Mem_Req) begin
          state_d = S_WAIT;
        end else begin
          pc_d    = pcInc;
          state_d = S_FETCH;
        end
      end
      S_WAIT: begin
        if (bus.i_Mem_Ready) begin
          pc_d    = pcInc;
          state_d = S_FETCH;
        end
      end
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Reset) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      sp_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      sp_q    <= sp_d;
      err_q   <= err_d;
    end
  end

  // Stack storage needs no reset; occupancy alone decides which entries are live.
  always_ff @(posedge i_Clk) begin
    if (i_Reset && push) begin
      stack_q[pushIdx] <= pcInc;
    end
  end

  assign bus.o_Pc        = pc_q;
  assign bus.o_Rom_En    = (state_q == S_FETCH);
  assign bus.o_Ir_Load   = (state_q == S_DECODE);
  assign bus.o_Exec_En   = (state_q == S_EXEC);
  assign bus.o_Halted    = (state_q == S_HALT);
  assign bus.o_Stack_Err = err_q;
  assign bus.o_Sp        = sp_q;
endmodule
